// File: rtl/parking_slot_allocator_pkg.sv
// Shared sizes, plate constants and FSM encoding for the parking slot allocator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package parking_slot_allocator_pkg;

    localparam int NUM_ZONES      = 4;
    localparam int SLOTS_PER_ZONE = 8;
    localparam int NUM_SLOTS      = NUM_ZONES * SLOTS_PER_ZONE;
    localparam int PLATE_W        = 7;
    localparam int SLOT_IDX_W     = $clog2(NUM_SLOTS);
    localparam int FREE_W         = $clog2(NUM_SLOTS + 1);

    localparam logic [PLATE_W-1:0]    PLATE_INVALID = '0;
    localparam logic [SLOT_IDX_W-1:0] LAST_SLOT     = SLOT_IDX_W'(NUM_SLOTS - 1);
    localparam logic [FREE_W-1:0]     FREE_AT_RESET = FREE_W'(NUM_SLOTS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/parking_slot_allocator_table.sv
// Slot register file: per slot a valid bit plus the parked plate code.
// Latency: combinational read, write lands on the next clk edge.
// Backpressure: none; the owner issues at most one write per cycle.
module parking_slot_table
    import parking_slot_allocator_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SLOT_IDX_W-1:0] i_rd_idx,
    output logic                  o_rd_valid,
    output logic [PLATE_W-1:0]    o_rd_plate,
    input  logic                  i_wr_en,
    input  logic                  i_wr_set,
    input  logic [SLOT_IDX_W-1:0] i_wr_idx,
    input  logic [PLATE_W-1:0]    i_wr_plate,
    output logic [NUM_SLOTS-1:0]  o_valid_vec
);

    logic [NUM_SLOTS-1:0] r_valid;
    logic [PLATE_W-1:0]   r_plate [NUM_SLOTS];

    // Set marks a slot occupied and stores its plate; clear only drops the valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_plate[i] <= PLATE_INVALID;
            end
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= i_wr_set;
            if (i_wr_set) begin
                r_plate[i_wr_idx] <= i_wr_plate;
            end
        end
    end

    assign o_rd_valid  = r_valid[i_rd_idx];
    assign o_rd_plate  = r_plate[i_rd_idx];
    assign o_valid_vec = r_valid;

endmodule

// File: rtl/parking_slot_allocator.sv
// Parks/releases plates: sequential 32-slot scan, then commit and a done pulse.
// Latency: fixed 33 cycles from accept to done, req_ready again one cycle later.
// Backpressure: req_ready only in IDLE; requests seen while busy are ignored.
module parking_slot_allocator
    import parking_slot_allocator_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arrive_req,
    input  logic                  depart_req,
    input  logic [PLATE_W-1:0]    plate_in,
    output logic                  req_ready,
    output logic                  done,
    output logic                  err,
    output logic [SLOT_IDX_W-1:0] slot_idx,
    output logic [7:0]            parq1_status,
    output logic [7:0]            parq2_status,
    output logic [7:0]            parq3_status,
    output logic [7:0]            parq4_status,
    output logic [PLATE_W-1:0]    placa1,
    output logic [PLATE_W-1:0]    placa2,
    output logic [FREE_W-1:0]     free_count,
    output logic                  full
);

    state_t                  r_state;
    state_t                  w_next_state;

    logic                    r_req_depart;
    logic [PLATE_W-1:0]      r_plate;
    logic [SLOT_IDX_W-1:0]   r_scan_cnt;
    logic                    r_free_found;
    logic [SLOT_IDX_W-1:0]   r_free_idx;
    logic                    r_match_found;
    logic [SLOT_IDX_W-1:0]   r_match_idx;
    logic                    r_err;
    logic [SLOT_IDX_W-1:0]   r_slot_idx;
    logic [PLATE_W-1:0]      r_placa1;
    logic [PLATE_W-1:0]      r_placa2;
    logic [FREE_W-1:0]       r_free_count;

    logic                    w_accept;
    logic                    w_rd_valid;
    logic [PLATE_W-1:0]      w_rd_plate;
    logic [NUM_SLOTS-1:0]    w_valid_vec;
    logic                    w_free_found;
    logic [SLOT_IDX_W-1:0]   w_free_idx;
    logic                    w_match_found;
    logic [SLOT_IDX_W-1:0]   w_match_idx;
    logic                    w_commit;
    logic                    w_ok_arrive;
    logic                    w_ok_depart;
    logic                    w_wr_en;
    logic [SLOT_IDX_W-1:0]   w_wr_idx;

    parking_slot_table u_table (
        .clk         (clk),
        .reset       (reset),
        .i_rd_idx    (r_scan_cnt),
        .o_rd_valid  (w_rd_valid),
        .o_rd_plate  (w_rd_plate),
        .i_wr_en     (w_wr_en),
        .i_wr_set    (!r_req_depart),
        .i_wr_idx    (w_wr_idx),
        .i_wr_plate  (r_plate),
        .o_valid_vec (w_valid_vec)
    );

    assign w_accept = (r_state == ST_IDLE) && (arrive_req || depart_req);

    // Fold the slot under the scan pointer into the running "lowest free" and "match" results.
    // The first hit is kept, so the free index is always the lowest one.
    assign w_free_found  = r_free_found || !w_rd_valid;
    assign w_free_idx    = r_free_found ? r_free_idx : r_scan_cnt;
    assign w_match_found = r_match_found || (w_rd_valid && (w_rd_plate == r_plate));
    assign w_match_idx   = r_match_found ? r_match_idx : r_scan_cnt;

    // The decision is taken on the last scan cycle so results are visible when done rises.
    assign w_commit    = (r_state == ST_SCAN) && (r_scan_cnt == LAST_SLOT);
    assign w_ok_arrive = !r_req_depart && (r_plate != PLATE_INVALID)
                         && w_free_found && !w_match_found;
    assign w_ok_depart = r_req_depart && w_match_found;
    assign w_wr_en     = w_commit && (w_ok_arrive || w_ok_depart);
    assign w_wr_idx    = r_req_depart ? w_match_idx : w_free_idx;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and handshake outputs; err only ever shows together with done.
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (arrive_req || depart_req) begin
                    w_next_state = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (r_scan_cnt == LAST_SLOT) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                done         = 1'b1;
                err          = r_err;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Latch the request on accept (depart wins when both are up) and walk the scan pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_depart  <= 1'b0;
            r_plate       <= PLATE_INVALID;
            r_scan_cnt    <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
        end else if (w_accept) begin
            r_req_depart  <= depart_req;
            r_plate       <= plate_in;
            r_scan_cnt    <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
        end else if (r_state == ST_SCAN) begin
            r_scan_cnt    <= r_scan_cnt + 1'b1;
            r_free_found  <= w_free_found;
            r_free_idx    <= w_free_idx;
            r_match_found <= w_match_found;
            r_match_idx   <= w_match_idx;
        end
    end

    // Commit the outcome; a rejected request only raises the error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err        <= 1'b0;
            r_slot_idx   <= '0;
            r_placa1     <= PLATE_INVALID;
            r_placa2     <= PLATE_INVALID;
            r_free_count <= FREE_AT_RESET;
        end else if (w_commit) begin
            r_err <= !(w_ok_arrive || w_ok_depart);
            if (w_ok_arrive) begin
                r_slot_idx   <= w_free_idx;
                r_placa1     <= r_plate;
                r_free_count <= r_free_count - 1'b1;
            end else if (w_ok_depart) begin
                r_slot_idx   <= w_match_idx;
                r_placa2     <= r_plate;
                r_free_count <= r_free_count + 1'b1;
            end
        end
    end

    assign slot_idx     = r_slot_idx;
    assign placa1       = r_placa1;
    assign placa2       = r_placa2;
    assign free_count   = r_free_count;
    assign full         = (r_free_count == '0);
    assign parq1_status = w_valid_vec[0*SLOTS_PER_ZONE +: SLOTS_PER_ZONE];
    assign parq2_status = w_valid_vec[1*SLOTS_PER_ZONE +: SLOTS_PER_ZONE];
    assign parq3_status = w_valid_vec[2*SLOTS_PER_ZONE +: SLOTS_PER_ZONE];
    assign parq4_status = w_valid_vec[3*SLOTS_PER_ZONE +: SLOTS_PER_ZONE];

endmodule
